pla_exhaustive_checker: RTL and testbench
=========================================

Name: pla_exhaustive_checker

Overview:
- Sequencer that sweeps every input minterm of an N_IN-input, single-output combinational PLA function. Drives each pattern into two instances of that function, a golden original and an optimized netlist, and compares their y0 outputs.
- Accumulates mismatch and onset counts and records the first failing vector.
- Sits in the equivalence-check harness around the benchmark netlists; one checker per output bit.

Parameters:
- N_IN, 16, width of the input vector driven to both function instances.
- SETTLE, 1, cycles each vector is held before sampling (≥1); covers registered wrappers around the DUTs.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin sweep; honoured only in IDLE
- abort  input  1  cancel sweep; return to IDLE
- stop_on_fail  input  1  end sweep at first mismatch; sampled with start
- vec_out  output  N_IN  current input vector to both instances
- y_ref  input  1  golden instance output
- y_dut  input  1  optimized instance output
- busy  output  1  high in APPLY/SAMPLE
- done  output  1  one-cycle pulse when sweep finishes (not on abort)
- pass  output  1  sticky: 1 iff last completed sweep had zero mismatches
- mismatch_count  output  N_IN+1  vectors where y_ref≠y_dut
- onset_count  output  N_IN+1  vectors where y_dut=1
- first_fail_vec  output  N_IN  vector of first mismatch
- first_fail_valid  output  1  first_fail_vec holds a real mismatch

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - vec_out=0, busy=0, done=0, pass=0.
  - counts=0, first_fail_vec=0, first_fail_valid=0.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - start=1 and abort=0 → APPLY. On that edge: vec_out=0, counts=0, first_fail_valid=0, first_fail_vec=0, pass=0, wait counter=0; stop_on_fail is latched.
  - start and abort both high → stay IDLE.
- APPLY:
  - Hold vec_out for exactly SETTLE cycles.
  - Then → SAMPLE.
- SAMPLE (one cycle): sample y_ref/y_dut.
  - y_dut=1 → onset_count+1.
  - y_ref≠y_dut → mismatch_count+1. If first_fail_valid=0, also set first_fail_vec=vec_out and first_fail_valid=1.
  - Mismatch and latched stop_on_fail → DONE.
  - Otherwise, vec_out=all-ones → DONE.
  - Otherwise vec_out+1 → APPLY. The sweep never wraps to 0.
- DONE (one cycle):
  - done=1.
  - pass = (mismatch_count==0), computed including the final SAMPLE update.
  - → IDLE.
- Timing:
  - Per vector: SETTLE+1 cycles.
  - Full sweep: start sampled in cycle 0; done high in cycle 2^N_IN·(SETTLE+1)+1.
- Abort:
  - In APPLY/SAMPLE/DONE → IDLE next edge; no done pulse.
  - Counts, first_fail and vec_out retain their last values; pass stays 0.
  - Abort coinciding with the final SAMPLE: abort wins, no count update.
- busy: high exactly in APPLY and SAMPLE.
- start outside IDLE is ignored.
- Counter width N_IN+1 holds 2^N_IN without overflow; no saturation logic.

Test Plan:
1. N_IN=4, SETTLE=2; y_ref=y_dut=vec[0]&vec[3]; start → done in cycle 49; pass=1, mismatch_count=0, onset_count=4, first_fail_valid=0.
2. N_IN=4, SETTLE=2; y_dut=y_ref^(vec==4'hA), y_ref=0; full sweep → mismatch_count=1, first_fail_vec=4'hA, first_fail_valid=1, pass=0, onset_count=1.
3. N_IN=4, SETTLE=2; stop_on_fail=1, y_dut=~y_ref → done in cycle 4; mismatch_count=1, first_fail_vec=0, vec_out=0.
4. N_IN=4; abort while vec_out=5 in APPLY → busy=0 next cycle, no done, vec_out stays 5; restart → counts cleared, full sweep passes.
5. N_IN=16, SETTLE=1, identical functions → done in cycle 131073; last sampled vec_out=16'hFFFF; mismatch_count=0; pass=1.
6. rst pulsed asynchronously mid-sweep (between edges) → all outputs zero immediately. Also: start+abort together in IDLE → stays IDLE; start while busy → no restart.

Source files
------------

// File: rtl/pla_chk_if.sv
// Bundle between the exhaustive checker and its harness: sweep control,
// the stimulus vector, both function outputs, and the sweep results.
interface pla_chk_if #(
    parameter int N_IN = 16
);
    logic            start;
    logic            abort;
    logic            stop_on_fail;
    logic [N_IN-1:0] vec_out;
    logic            y_ref;
    logic            y_dut;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   mismatch_count;
    logic [N_IN:0]   onset_count;
    logic [N_IN-1:0] first_fail_vec;
    logic            first_fail_valid;

    modport master (
        input  start, abort, stop_on_fail, y_ref, y_dut,
        output vec_out, busy, done, pass, mismatch_count, onset_count,
               first_fail_vec, first_fail_valid
    );

    modport slave (
        output start, abort, stop_on_fail, y_ref, y_dut,
        input  vec_out, busy, done, pass, mismatch_count, onset_count,
               first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/pla_exhaustive_checker.sv
// Walks every input minterm into a golden and an optimized PLA instance,
// counting output mismatches / onset and capturing the first failing vector.
module pla_exhaustive_checker #(
    parameter int N_IN   = 16,
    parameter int SETTLE = 1
) (
    input  logic      clk,
    input  logic      rst,
    pla_chk_if.master bus
);
    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SAMPLE, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [WW-1:0]   r_wait;
    logic [N_IN-1:0] r_vec;
    logic [N_IN-1:0] r_ffv;
    logic            r_ffvalid;
    logic [N_IN:0]   r_mm;
    logic [N_IN:0]   r_on;
    logic            r_pass;
    logic            r_stop;
    logic            w_mis;
    logic            w_last;
    logic            w_settled;

    assign w_mis     = bus.y_ref ^ bus.y_dut;
    assign w_last    = &r_vec;
    assign w_settled = (r_wait == WW'(SETTLE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (bus.start && !bus.abort) w_next = S_APPLY;
            S_APPLY: begin
                if (bus.abort)      w_next = S_IDLE;
                else if (w_settled) w_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (bus.abort)                         w_next = S_IDLE;
                else if ((w_mis && r_stop) || w_last)  w_next = S_DONE;
                else                                   w_next = S_APPLY;
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait    <= '0;
            r_vec     <= '0;
            r_ffv     <= '0;
            r_ffvalid <= 1'b0;
            r_mm      <= '0;
            r_on      <= '0;
            r_pass    <= 1'b0;
            r_stop    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_wait    <= '0;
                        r_vec     <= '0;
                        r_ffv     <= '0;
                        r_ffvalid <= 1'b0;
                        r_mm      <= '0;
                        r_on      <= '0;
                        r_pass    <= 1'b0;
                        r_stop    <= bus.stop_on_fail;
                    end
                end
                S_APPLY: begin
                    if (w_settled) r_wait <= '0;
                    else           r_wait <= r_wait + 1'b1;
                end
                S_SAMPLE: begin
                    // An abort landing on the sample cycle discards that sample.
                    if (!bus.abort) begin
                        if (bus.y_dut) r_on <= r_on + 1'b1;
                        if (w_mis) begin
                            r_mm <= r_mm + 1'b1;
                            if (!r_ffvalid) begin
                                r_ffv     <= r_vec;
                                r_ffvalid <= 1'b1;
                            end
                        end
                        if (w_next == S_APPLY) r_vec <= r_vec + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!bus.abort) r_pass <= (r_mm == '0);
                end
                default: ;
            endcase
        end
    end

    assign bus.vec_out          = r_vec;
    assign bus.busy             = (r_state == S_APPLY) || (r_state == S_SAMPLE);
    assign bus.done             = (r_state == S_DONE) && !bus.abort;
    assign bus.pass             = r_pass;
    assign bus.mismatch_count   = r_mm;
    assign bus.onset_count      = r_on;
    assign bus.first_fail_vec   = r_ffv;
    assign bus.first_fail_valid = r_ffvalid;
endmodule

// File: tb/tb_pla_exhaustive_checker.sv
// Bench for pla_exhaustive_checker: a 4-input/SETTLE=2 instance driven from
// lookup-table functions and a 12-input/SETTLE=1 instance for a long sweep.
module tb_pla_exhaustive_checker;
    localparam int NA = 4;
    localparam int SA = 2;
    localparam int NB = 12;
    localparam int SB = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pla_chk_if #(.N_IN(NA)) a_if();
    pla_chk_if #(.N_IN(NB)) b_if();

    pla_exhaustive_checker #(.N_IN(NA), .SETTLE(SA)) dut_a (.clk(clk), .rst(rst), .bus(a_if.master));
    pla_exhaustive_checker #(.N_IN(NB), .SETTLE(SB)) dut_b (.clk(clk), .rst(rst), .bus(b_if.master));

    logic [15:0] lut_ref, lut_dut;
    assign a_if.y_ref = lut_ref[a_if.vec_out];
    assign a_if.y_dut = lut_dut[a_if.vec_out];
    assign b_if.y_ref = ^b_if.vec_out;
    assign b_if.y_dut = ^b_if.vec_out;

    typedef struct {
        logic [15:0] r;
        logic [15:0] d;
        bit          stop;
        int          mm;
        int          on;
        int          ffv;
        bit          ffvalid;
        bit          pass;
        int          cyc;
        int          lastv;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk the minterms in order and apply the rules directly.
    function automatic exp_t model(input logic [15:0] r, input logic [15:0] d, input bit stop);
        exp_t e;
        int   n;
        e.r = r; e.d = d; e.stop = stop;
        e.mm = 0; e.on = 0; e.ffv = 0; e.ffvalid = 0; e.lastv = 0;
        n = 0;
        for (int v = 0; v < 16; v++) begin
            n++;
            e.lastv = v;
            if (d[v]) e.on++;
            if (r[v] != d[v]) begin
                e.mm++;
                if (!e.ffvalid) begin e.ffv = v; e.ffvalid = 1; end
                if (stop) break;
            end
        end
        e.pass = (e.mm == 0);
        e.cyc  = n * (SA + 1) + 1;
        return e;
    endfunction

    task automatic sweep_a(input exp_t e, input string tag, input int inj);
        lut_ref = e.r;
        lut_dut = e.d;
        a_if.stop_on_fail = e.stop;
        a_if.start = 1'b1;
        @(posedge clk); #1;
        a_if.start = 1'b0;
        a_if.stop_on_fail = 1'b0;
        cyc = 1;
        while (!a_if.done && cyc < 200) begin
            if (cyc == inj) a_if.start = 1'b1;
            @(posedge clk); #1;
            a_if.start = 1'b0;
            cyc++;
        end
        chk({tag, ".done_cyc"}, cyc, e.cyc);
        chk({tag, ".mm"}, 32'(a_if.mismatch_count), e.mm);
        chk({tag, ".on"}, 32'(a_if.onset_count), e.on);
        chk({tag, ".ffv"}, 32'(a_if.first_fail_vec), e.ffv);
        chk({tag, ".ffvalid"}, 32'(a_if.first_fail_valid), 32'(e.ffvalid));
        chk({tag, ".vec"}, 32'(a_if.vec_out), e.lastv);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, 32'(a_if.done), 0);
        chk({tag, ".busy_after"}, 32'(a_if.busy), 0);
        chk({tag, ".pass"}, 32'(a_if.pass), 32'(e.pass));
    endtask

    task automatic run_to(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic start_a(input logic [15:0] r, input logic [15:0] d, input bit stop);
        lut_ref = r;
        lut_dut = d;
        a_if.stop_on_fail = stop;
        a_if.start = 1'b1;
        @(posedge clk); #1;
        a_if.start = 1'b0;
        cyc = 1;
    endtask

    exp_t tbl[6];
    exp_t e;
    int   seen_done;

    initial begin
        tbl[0] = '{16'hAA00, 16'hAA00, 0, 0,  4, 0,  0, 1, 49, 15};
        tbl[1] = '{16'h0000, 16'h0400, 0, 1,  1, 10, 1, 0, 49, 15};
        tbl[2] = '{16'h0000, 16'hFFFF, 1, 1,  1, 0,  1, 0, 4,  0};
        tbl[3] = '{16'h00F0, 16'h00D0, 1, 1,  1, 5,  1, 0, 19, 5};
        tbl[4] = '{16'hFFFF, 16'h7FFF, 1, 1,  15, 15, 1, 0, 49, 15};
        tbl[5] = '{16'h1234, 16'h1234, 1, 0,  5, 0,  0, 1, 49, 15};

        rst = 1'b1;
        a_if.start = 0; a_if.abort = 0; a_if.stop_on_fail = 0;
        b_if.start = 0; b_if.abort = 0; b_if.stop_on_fail = 0;
        lut_ref = '0; lut_dut = '0;
        #12;
        chk("rst.vec", 32'(a_if.vec_out), 0);
        chk("rst.busy", 32'(a_if.busy), 0);
        chk("rst.done", 32'(a_if.done), 0);
        chk("rst.pass", 32'(a_if.pass), 0);
        chk("rst.mm", 32'(a_if.mismatch_count), 0);
        chk("rst.on", 32'(a_if.onset_count), 0);
        chk("rst.ffvalid", 32'(a_if.first_fail_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) sweep_a(tbl[i], $sformatf("tbl%0d", i), -1);

        for (int i = 0; i < 6; i++) begin
            logic [15:0] r, flip;
            r = 16'($urandom);
            flip = '0;
            if ($urandom_range(0, 2) != 0) flip = 16'h1 << $urandom_range(0, 15);
            if ($urandom_range(0, 1) != 0) flip = flip | (16'h1 << $urandom_range(0, 15));
            e = model(r, r ^ flip, bit'($urandom_range(0, 1)));
            sweep_a(e, $sformatf("rnd%0d", i), -1);
        end

        // start while busy must not restart the sweep
        sweep_a(tbl[0], "busy_start", 10);

        // start and abort together in IDLE
        a_if.start = 1'b1; a_if.abort = 1'b1;
        @(posedge clk); #1;
        a_if.start = 1'b0; a_if.abort = 1'b0;
        chk("start_abort.busy", 32'(a_if.busy), 0);
        @(posedge clk); #1;
        chk("start_abort.busy2", 32'(a_if.busy), 0);

        // abort while vector 5 is in its settle window
        start_a(16'hFFFF, 16'hFFFF, 0);
        run_to(16);
        chk("abort.busy_before", 32'(a_if.busy), 1);
        chk("abort.vec_before", 32'(a_if.vec_out), 5);
        a_if.abort = 1'b1;
        @(posedge clk); #1;
        a_if.abort = 1'b0;
        chk("abort.busy", 32'(a_if.busy), 0);
        chk("abort.vec", 32'(a_if.vec_out), 5);
        chk("abort.on", 32'(a_if.onset_count), 5);
        seen_done = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (a_if.done || a_if.busy) seen_done++;
        end
        chk("abort.no_done", seen_done, 0);
        chk("abort.pass", 32'(a_if.pass), 0);
        chk("abort.vec_hold", 32'(a_if.vec_out), 5);
        sweep_a(tbl[0], "restart", -1);

        // abort coincident with the final sample: sample is dropped
        start_a(16'hFFFF, 16'h7FFF, 0);
        run_to(48);
        chk("abort_last.vec", 32'(a_if.vec_out), 15);
        a_if.abort = 1'b1;
        @(posedge clk); #1;
        a_if.abort = 1'b0;
        chk("abort_last.busy", 32'(a_if.busy), 0);
        chk("abort_last.done", 32'(a_if.done), 0);
        chk("abort_last.mm", 32'(a_if.mismatch_count), 0);
        chk("abort_last.on", 32'(a_if.onset_count), 15);
        chk("abort_last.ffvalid", 32'(a_if.first_fail_valid), 0);
        @(posedge clk); #1;
        chk("abort_last.done2", 32'(a_if.done), 0);
        chk("abort_last.pass", 32'(a_if.pass), 0);

        // asynchronous reset between edges mid-sweep
        start_a(16'h0000, 16'h0400, 0);
        run_to(45);
        chk("arst.mm_before", 32'(a_if.mismatch_count), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst.vec", 32'(a_if.vec_out), 0);
        chk("arst.busy", 32'(a_if.busy), 0);
        chk("arst.mm", 32'(a_if.mismatch_count), 0);
        chk("arst.on", 32'(a_if.onset_count), 0);
        chk("arst.ffv", 32'(a_if.first_fail_vec), 0);
        chk("arst.ffvalid", 32'(a_if.first_fail_valid), 0);
        chk("arst.done", 32'(a_if.done), 0);
        chk("arst.pass", 32'(a_if.pass), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // long sweep on the wide instance, identical functions
        b_if.start = 1'b1;
        @(posedge clk); #1;
        b_if.start = 1'b0;
        cyc = 1;
        while (!b_if.done && cyc < 9000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("wide.done_cyc", cyc, (1 << NB) * (SB + 1) + 1);
        chk("wide.vec", 32'(b_if.vec_out), (1 << NB) - 1);
        chk("wide.mm", 32'(b_if.mismatch_count), 0);
        chk("wide.on", 32'(b_if.onset_count), 1 << (NB - 1));
        @(posedge clk); #1;
        chk("wide.pass", 32'(b_if.pass), 1);
        chk("wide.vec_nowrap", 32'(b_if.vec_out), (1 << NB) - 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
